vga_bus_reader: RTL and testbench

CPU read-side responder for the VGA peripheral. It detects 6502 read cycles (EN low, RW high, CLK_CPU high), drives the register or framebuffer byte onto the data transceiver, and controls DIR. It prefetches the framebuffer byte at the current address so DATA_REG reads need no wait states. It issues auto-increment requests and interrupt-clear pulses back to the existing write-side register block.

---
 rtl/vga_bus_reader.sv | 251 +++++++++++++++++++++++++
 tb/tb_vga_bus_reader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_bus_reader.sv
// CPU read-side responder for the VGA peripheral: serves 6502 register reads, keeps a prefetched
// framebuffer byte ready for DATA reads, and issues auto-increment / interrupt-clear pulses.
module vga_bus_reader #(
    parameter int unsigned RAM_LATENCY  = 2,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned ACK_TIMEOUT  = 8,
    parameter logic [13:0] SCREEN_CHARS = 14'h1D4B
) (
    input  logic        CLK_FAST,
    input  logic        RESET,
    input  logic        CLK_CPU,
    input  logic        EN,
    input  logic        RW,
    input  logic [2:0]  REG,
    output logic [7:0]  DATA_OUT,
    output logic        DATA_OE,
    output logic        DIR,
    input  logic [7:0]  ctrl_val,
    input  logic [13:0] addr_val,
    input  logic [7:0]  ien_val,
    input  logic [7:0]  intr_val,
    input  logic [7:0]  hscroll_val,
    input  logic [7:0]  vscroll_val,
    input  logic [7:0]  bgcolor_val,
    input  logic [7:0]  fgcolor_val,
    output logic        fb_rd_en,
    output logic [13:0] fb_rd_addr,
    input  logic [7:0]  fb_rd_data,
    input  logic        addr_dirty,
    output logic        inc_req,
    output logic [7:0]  intr_clr
);

    localparam int unsigned LatW = $clog2(RAM_LATENCY + 2);
    localparam int unsigned ToW  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic {StIdle, StServe} acc_state_e;
    typedef enum logic [1:0] {StInvalid, StFetch, StValid, StWaitAck} pf_state_e;

    logic [SYNC_STAGES-1:0]      phi2_sync_q, en_sync_q, rw_sync_q;
    logic [SYNC_STAGES-1:0][2:0] reg_sync_q;
    logic                        phi2_s, en_s, rw_s, rd_hit;
    logic [2:0]                  reg_s;

    always_ff @(posedge CLK_FAST or posedge RESET) begin
        if (RESET) begin
            phi2_sync_q <= '0;
            en_sync_q   <= '1;
            rw_sync_q   <= '0;
            reg_sync_q  <= '0;
        end else begin
            phi2_sync_q[0] <= CLK_CPU;
            en_sync_q[0]   <= EN;
            rw_sync_q[0]   <= RW;
            reg_sync_q[0]  <= REG;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                phi2_sync_q[i] <= phi2_sync_q[i-1];
                en_sync_q[i]   <= en_sync_q[i-1];
                rw_sync_q[i]   <= rw_sync_q[i-1];
                reg_sync_q[i]  <= reg_sync_q[i-1];
            end
        end
    end

    assign phi2_s = phi2_sync_q[SYNC_STAGES-1];
    assign en_s   = en_sync_q[SYNC_STAGES-1];
    assign rw_s   = rw_sync_q[SYNC_STAGES-1];
    assign reg_s  = reg_sync_q[SYNC_STAGES-1];
    assign rd_hit = phi2_s & ~en_s & rw_s;

    acc_state_e  acc_q, acc_d;
    logic [2:0]  sel_q, sel_d;
    logic [7:0]  intr_frz_q, intr_frz_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        data_oe_q, data_oe_d;
    logic        dir_q, dir_d;
    logic        inc_req_q, inc_req_d;
    logic [7:0]  intr_clr_q, intr_clr_d;

    pf_state_e   pf_q, pf_d;
    logic [7:0]  pf_byte_q, pf_byte_d;
    logic [LatW-1:0] lat_cnt_q, lat_cnt_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic        fb_rd_en_q, fb_rd_en_d;
    logic [13:0] fb_rd_addr_q, fb_rd_addr_d;

    logic [2:0]  src_sel;
    logic [7:0]  src_intr, rd_byte, direct_byte;
    logic        needs_ram;

    // On the entry edge the source is the live REG/INTR; afterwards the latched copies.
    always_comb begin
        src_sel  = (acc_q == StIdle) ? reg_s : sel_q;
        src_intr = (acc_q == StIdle) ? intr_val : intr_frz_q;
        rd_byte  = 8'h00;
        unique case (src_sel)
            3'd0: rd_byte = ctrl_val;
            3'd1: rd_byte = {3'b000, addr_val[4:0]};
            3'd2: rd_byte = addr_val[12:5];
            3'd3: rd_byte = (pf_q == StValid) ? pf_byte_q : 8'h00;
            3'd4: rd_byte = ien_val;
            3'd5: rd_byte = src_intr;
            3'd6: rd_byte = hscroll_val;
            3'd7: rd_byte = vscroll_val;
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        direct_byte = 8'h00;
        needs_ram   = 1'b0;
        if (addr_val == 14'h1FFE) begin
            direct_byte = bgcolor_val;
        end else if (addr_val == 14'h1FFF) begin
            direct_byte = fgcolor_val;
        end else if (addr_val >= SCREEN_CHARS) begin
            direct_byte = 8'h00;
        end else begin
            needs_ram = 1'b1;
        end
    end

    always_comb begin
        acc_d      = acc_q;
        sel_d      = sel_q;
        intr_frz_d = intr_frz_q;
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;
        dir_d      = dir_q;
        inc_req_d  = 1'b0;
        intr_clr_d = 8'h00;
        unique case (acc_q)
            StIdle: begin
                if (rd_hit) begin
                    acc_d      = StServe;
                    sel_d      = reg_s;
                    intr_frz_d = intr_val;
                    data_out_d = rd_byte;
                    data_oe_d  = 1'b1;
                    dir_d      = 1'b0;
                end
            end
            StServe: begin
                if (rd_hit) begin
                    data_out_d = rd_byte;
                end else begin
                    acc_d     = StIdle;
                    data_oe_d = 1'b0;
                    dir_d     = 1'b1;
                    if (sel_q == 3'd3) inc_req_d = 1'b1;
                    if (sel_q == 3'd5) intr_clr_d = intr_frz_q;
                end
            end
            default: acc_d = StIdle;
        endcase
    end

    always_comb begin
        pf_d         = pf_q;
        pf_byte_d    = pf_byte_q;
        lat_cnt_d    = lat_cnt_q;
        to_cnt_d     = to_cnt_q;
        fb_rd_en_d   = 1'b0;
        fb_rd_addr_d = fb_rd_addr_q;
        unique case (pf_q)
            StInvalid: begin
                fb_rd_addr_d = addr_val;
                if (!addr_dirty) begin
                    if (needs_ram) begin
                        fb_rd_en_d = 1'b1;
                        lat_cnt_d  = '0;
                        pf_d       = StFetch;
                    end else begin
                        pf_byte_d = direct_byte;
                        pf_d      = StValid;
                    end
                end
            end
            StFetch: begin
                if (addr_dirty) begin
                    pf_d = StInvalid;
                end else if (lat_cnt_q == LatW'(RAM_LATENCY)) begin
                    pf_byte_d = fb_rd_data;
                    pf_d      = StValid;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            StValid: begin
                if (addr_dirty) pf_d = StInvalid;
            end
            StWaitAck: begin
                if (addr_dirty || to_cnt_q == ToW'(ACK_TIMEOUT - 1)) begin
                    pf_d = StInvalid;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: pf_d = StInvalid;
        endcase
        // The increment makes the held byte stale until the write side acknowledges it.
        if (inc_req_d) begin
            pf_d       = StWaitAck;
            to_cnt_d   = '0;
            fb_rd_en_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_FAST or posedge RESET) begin
        if (RESET) begin
            acc_q        <= StIdle;
            sel_q        <= 3'd0;
            intr_frz_q   <= 8'h00;
            data_out_q   <= 8'h00;
            data_oe_q    <= 1'b0;
            dir_q        <= 1'b1;
            inc_req_q    <= 1'b0;
            intr_clr_q   <= 8'h00;
            pf_q         <= StInvalid;
            pf_byte_q    <= 8'h00;
            lat_cnt_q    <= '0;
            to_cnt_q     <= '0;
            fb_rd_en_q   <= 1'b0;
            fb_rd_addr_q <= 14'h0000;
        end else begin
            acc_q        <= acc_d;
            sel_q        <= sel_d;
            intr_frz_q   <= intr_frz_d;
            data_out_q   <= data_out_d;
            data_oe_q    <= data_oe_d;
            dir_q        <= dir_d;
            inc_req_q    <= inc_req_d;
            intr_clr_q   <= intr_clr_d;
            pf_q         <= pf_d;
            pf_byte_q    <= pf_byte_d;
            lat_cnt_q    <= lat_cnt_d;
            to_cnt_q     <= to_cnt_d;
            fb_rd_en_q   <= fb_rd_en_d;
            fb_rd_addr_q <= fb_rd_addr_d;
        end
    end

    assign DATA_OUT   = data_out_q;
    assign DATA_OE    = data_oe_q;
    assign DIR        = dir_q;
    assign inc_req    = inc_req_q;
    assign intr_clr   = intr_clr_q;
    assign fb_rd_en   = fb_rd_en_q;
    assign fb_rd_addr = fb_rd_addr_q;

endmodule

// File: tb/tb_vga_bus_reader.sv
// Directed bench for vga_bus_reader: register-read table, prefetch/increment sequences,
// interrupt freeze, ack timeout, write rejection and mid-access reset.
module tb_vga_bus_reader;

    logic        CLK_FAST = 1'b0;
    logic        RESET = 1'b1;
    logic        CLK_CPU = 1'b0;
    logic        EN = 1'b1;
    logic        RW = 1'b1;
    logic [2:0]  REG = 3'd0;
    logic [7:0]  DATA_OUT;
    logic        DATA_OE, DIR;
    logic [7:0]  ctrl_val = 8'h05, ien_val = 8'h3C, intr_val = 8'hA5;
    logic [7:0]  hscroll_val = 8'h11, vscroll_val = 8'h22;
    logic [7:0]  bgcolor_val = 8'h9B, fgcolor_val = 8'hE7;
    logic [13:0] addr_val = 14'h0000;
    logic        fb_rd_en;
    logic [13:0] fb_rd_addr;
    logic [7:0]  fb_rd_data;
    logic        addr_dirty = 1'b0;
    logic        inc_req;
    logic [7:0]  intr_clr;

    vga_bus_reader dut (
        .CLK_FAST(CLK_FAST), .RESET(RESET), .CLK_CPU(CLK_CPU), .EN(EN), .RW(RW), .REG(REG),
        .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DIR(DIR),
        .ctrl_val(ctrl_val), .addr_val(addr_val), .ien_val(ien_val), .intr_val(intr_val),
        .hscroll_val(hscroll_val), .vscroll_val(vscroll_val),
        .bgcolor_val(bgcolor_val), .fgcolor_val(fgcolor_val),
        .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
        .addr_dirty(addr_dirty), .inc_req(inc_req), .intr_clr(intr_clr)
    );

    always #5 CLK_FAST = ~CLK_FAST;

    // Two-stage RAM model: data sampled two edges after the strobe; garbage otherwise.
    logic [7:0] fb_mem [0:16383];
    logic [7:0] ram_p0 = 8'hEE, ram_p1 = 8'hEE;
    always @(posedge CLK_FAST) begin
        ram_p0 <= fb_rd_en ? fb_mem[fb_rd_addr] : 8'hEE;
        ram_p1 <= ram_p0;
    end
    assign fb_rd_data = ram_p1;

    int fb_rd_cnt = 0, inc_cnt = 0, clr_cyc = 0;
    logic [7:0] clr_last = 8'h00;
    always @(negedge CLK_FAST) begin
        if (fb_rd_en) fb_rd_cnt <= fb_rd_cnt + 1;
        if (inc_req) inc_cnt <= inc_cnt + 1;
        if (intr_clr != 8'h00) begin
            clr_cyc  <= clr_cyc + 1;
            clr_last <= intr_clr;
        end
    end

    int total = 0, bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cpu_read(input logic [2:0] r, input int hold, output logic [7:0] d0,
                            output logic [7:0] d, output logic dir_srv,
                            output int t_on, output int t_off);
        @(negedge CLK_FAST);
        REG = r; EN = 1'b0; RW = 1'b1;
        @(negedge CLK_FAST);
        CLK_CPU = 1'b1;
        t_on = 0;
        do begin @(negedge CLK_FAST); t_on++; end while (!DATA_OE && t_on < 12);
        d0 = DATA_OUT;
        dir_srv = DIR;
        repeat (hold) @(negedge CLK_FAST);
        d = DATA_OUT;
        CLK_CPU = 1'b0; EN = 1'b1;
        t_off = 0;
        do begin @(negedge CLK_FAST); t_off++; end while (DATA_OE && t_off < 12);
    endtask

    task automatic set_addr(input logic [13:0] a);
        @(negedge CLK_FAST);
        addr_val = a; addr_dirty = 1'b1;
        @(negedge CLK_FAST);
        addr_dirty = 1'b0;
        repeat (12) @(negedge CLK_FAST);
    endtask

    typedef struct {
        logic [2:0]  sel;
        logic [13:0] addr;
        logic [7:0]  exp;
        logic        no_ram;
    } vec_t;
    vec_t vecs [13];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d0, d;
        logic dir_srv;
        int t_on, t_off, inc0, clr0, fbc0, k;
        logic flag;

        for (int i = 0; i < 16384; i++) fb_mem[i] = 8'(i) ^ 8'h5A;
        fb_mem[14'h0123] = 8'h41;
        fb_mem[14'h0124] = 8'h42;

        vecs[0]  = '{3'd0, 14'h0123, 8'h05, 1'b0};
        vecs[1]  = '{3'd1, 14'h0ABC, 8'h1C, 1'b0};
        vecs[2]  = '{3'd2, 14'h0ABC, 8'h55, 1'b0};
        vecs[3]  = '{3'd2, 14'h3FFF, 8'hFF, 1'b0};
        vecs[4]  = '{3'd4, 14'h0010, 8'h3C, 1'b0};
        vecs[5]  = '{3'd5, 14'h0010, 8'hA5, 1'b0};
        vecs[6]  = '{3'd6, 14'h0010, 8'h11, 1'b0};
        vecs[7]  = '{3'd7, 14'h0010, 8'h22, 1'b0};
        vecs[8]  = '{3'd3, 14'h1FFE, 8'h9B, 1'b1};
        vecs[9]  = '{3'd3, 14'h1FFF, 8'hE7, 1'b1};
        vecs[10] = '{3'd3, 14'h1E00, 8'h00, 1'b1};
        vecs[11] = '{3'd3, 14'h1D4B, 8'h00, 1'b1};
        vecs[12] = '{3'd3, 14'h1D4A, 8'h10, 1'b0};

        // Reset state
        repeat (3) @(negedge CLK_FAST);
        check("rst_data_out", DATA_OUT, 8'h00);
        check("rst_data_oe", DATA_OE, 1'b0);
        check("rst_dir", DIR, 1'b1);
        check("rst_fb_rd_en", fb_rd_en, 1'b0);
        check("rst_fb_rd_addr", fb_rd_addr, 14'h0000);
        check("rst_inc_req", inc_req, 1'b0);
        check("rst_intr_clr", intr_clr, 8'h00);
        RESET = 1'b0;
        repeat (15) @(negedge CLK_FAST);

        // CTRL read with exact latency on both edges
        inc0 = inc_cnt; clr0 = clr_cyc;
        cpu_read(3'd0, 4, d0, d, dir_srv, t_on, t_off);
        repeat (2) @(negedge CLK_FAST);
        check("ctrl_t_on", t_on, 3);
        check("ctrl_t_off", t_off, 3);
        check("ctrl_data", d, 8'h05);
        check("ctrl_dir_serve", dir_srv, 1'b0);
        check("ctrl_dir_release", DIR, 1'b1);
        check("ctrl_no_inc", inc_cnt - inc0, 0);
        check("ctrl_no_clr", clr_cyc - clr0, 0);

        // Read-map table
        for (int i = 0; i < 13; i++) begin
            fbc0 = fb_rd_cnt;
            set_addr(vecs[i].addr);
            inc0 = inc_cnt; clr0 = clr_cyc;
            cpu_read(vecs[i].sel, 4, d0, d, dir_srv, t_on, t_off);
            repeat (15) @(negedge CLK_FAST);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp);
            check($sformatf("vec%0d_t_on", i), t_on, 3);
            check($sformatf("vec%0d_t_off", i), t_off, 3);
            check($sformatf("vec%0d_inc", i), inc_cnt - inc0, (vecs[i].sel == 3'd3) ? 1 : 0);
            check($sformatf("vec%0d_clr", i), clr_cyc - clr0, (vecs[i].sel == 3'd5) ? 1 : 0);
            if (vecs[i].no_ram) check($sformatf("vec%0d_no_ram", i), fb_rd_cnt - fbc0, 0);
        end

        // DATA read, then increment acknowledged with read started in the same cycle
        set_addr(14'h0123);
        inc0 = inc_cnt;
        cpu_read(3'd3, 4, d0, d, dir_srv, t_on, t_off);
        repeat (2) @(negedge CLK_FAST);
        check("data123", d, 8'h41);
        check("data123_inc", inc_cnt - inc0, 1);
        @(negedge CLK_FAST);
        REG = 3'd3; EN = 1'b0; RW = 1'b1;
        @(negedge CLK_FAST);
        addr_val = 14'h0124; addr_dirty = 1'b1; CLK_CPU = 1'b1;
        @(negedge CLK_FAST);
        addr_dirty = 1'b0;
        t_on = 1;
        while (!DATA_OE && t_on < 12) begin @(negedge CLK_FAST); t_on++; end
        check("data124_oe_lat", t_on, 3);
        check("data124_first", DATA_OUT, 8'h00);
        repeat (4) @(negedge CLK_FAST);
        check("data124_updated", DATA_OUT, 8'h42);
        inc0 = inc_cnt;
        CLK_CPU = 1'b0; EN = 1'b1;
        repeat (5) @(negedge CLK_FAST);
        check("data124_inc", inc_cnt - inc0, 1);
        check("data124_released", DATA_OE, 1'b0);

        // INTR frozen at access start, cleared exactly once
        repeat (12) @(negedge CLK_FAST);
        intr_val = 8'h81;
        inc0 = inc_cnt; clr0 = clr_cyc;
        fork
            begin
                repeat (5) @(negedge CLK_FAST);
                intr_val = 8'h83;
            end
        join_none
        cpu_read(3'd5, 6, d0, d, dir_srv, t_on, t_off);
        repeat (3) @(negedge CLK_FAST);
        check("intr_frozen", d, 8'h81);
        check("intr_clr_cycles", clr_cyc - clr0, 1);
        check("intr_clr_value", clr_last, 8'h81);
        check("intr_no_inc", inc_cnt - inc0, 0);
        intr_val = 8'hA5;

        // Increment never acknowledged: refetch after the timeout
        set_addr(14'h0200);
        cpu_read(3'd3, 2, d0, d, dir_srv, t_on, t_off);
        check("to_data", d, 8'h5A);
        fbc0 = fb_rd_cnt;
        k = 0;
        do begin @(negedge CLK_FAST); k++; end while (!fb_rd_en && k < 20);
        check("to_refetch_window", (k >= 8 && k <= 10), 1'b1);
        check("to_refetch_addr", fb_rd_addr, 14'h0200);
        repeat (12) @(negedge CLK_FAST);
        check("to_single_fetch", fb_rd_cnt - fbc0, 1);

        // Writes are ignored
        inc0 = inc_cnt;
        flag = 1'b0;
        @(negedge CLK_FAST);
        REG = 3'd3; EN = 1'b0; RW = 1'b0;
        @(negedge CLK_FAST);
        CLK_CPU = 1'b1;
        repeat (10) begin
            @(negedge CLK_FAST);
            if (!DIR || DATA_OE) flag = 1'b1;
        end
        CLK_CPU = 1'b0; EN = 1'b1; RW = 1'b1;
        repeat (4) @(negedge CLK_FAST);
        check("write_ignored", flag, 1'b0);
        check("write_no_inc", inc_cnt - inc0, 0);

        // Reset in the middle of a DATA read
        set_addr(14'h0300);
        @(negedge CLK_FAST);
        REG = 3'd3; EN = 1'b0; RW = 1'b1;
        @(negedge CLK_FAST);
        CLK_CPU = 1'b1;
        t_on = 0;
        do begin @(negedge CLK_FAST); t_on++; end while (!DATA_OE && t_on < 12);
        check("rstmid_oe_before", DATA_OE, 1'b1);
        inc0 = inc_cnt;
        #2 RESET = 1'b1;
        #1;
        check("rstmid_oe", DATA_OE, 1'b0);
        check("rstmid_dir", DIR, 1'b1);
        @(negedge CLK_FAST);
        CLK_CPU = 1'b0; EN = 1'b1;
        repeat (3) @(negedge CLK_FAST);
        RESET = 1'b0;
        k = 0;
        do begin @(negedge CLK_FAST); k++; end while (!fb_rd_en && k < 15);
        check("rstmid_refetch", fb_rd_en, 1'b1);
        check("rstmid_refetch_addr", fb_rd_addr, 14'h0300);
        repeat (6) @(negedge CLK_FAST);
        check("rstmid_no_inc", inc_cnt - inc0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
